bact_accum: RTL and testbench

//  Multi-channel, multi-beat binary activation unit for the BNN datapath.

---
 rtl/bact_accum.sv | 161 ++++++++++++++++
 tb/tb_bact_accum.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bact_accum.sv
// ---------------------------------------------------------------------------
// bact_accum
//   Multi-channel, multi-beat binary activation unit for the BNN datapath.
//   Each beat carries one signed partial sum per channel from the
//   XNOR-popcount stage. The unit adds these into per-channel saturating
//   accumulators. On the last beat of a vector it compares every total with
//   that channel's threshold and holds the resulting activation vector until
//   the consumer accepts it.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   thr_we/thr_ch/thr_data  threshold register file write (any state)
//   in_valid/in_ready     partial-sum beat handshake
//   in_data               NCH signed IW-bit partial sums, channel c at [c*IW +: IW]
//   in_last               marks the final beat of a vector
//   out_valid/out_ready   activation vector handshake
//   out_bits              bit c = (acc[c] >= thr[c]), signed compare
//   out_sat               bit c = accumulator c saturated during the vector
// ---------------------------------------------------------------------------
module bact_accum #(
    parameter int NCH = 4,
    parameter int IW  = 4,
    parameter int AW  = 12,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              thr_we,
    input  logic [CW-1:0]     thr_ch,
    input  logic [AW-1:0]     thr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*IW-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH-1:0]    out_bits,
    output logic [NCH-1:0]    out_sat
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic signed [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

    state_t state, state_next;

    logic signed [AW-1:0] acc     [NCH];
    logic signed [AW-1:0] thr     [NCH];
    logic        [NCH-1:0] sat;

    logic signed [AW:0]   beat_ext [NCH];
    logic signed [AW:0]   sum_wide [NCH];
    logic signed [AW-1:0] sum_sat  [NCH];
    logic        [NCH-1:0] sat_now;

    logic accept;
    logic deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    // Per-channel add with one guard bit. When the two top bits of the wide
    // sum disagree the result left the AW-bit range, and the guard bit tells
    // which rail to clamp to.
    always_comb begin
        sat_now = '0;
        for (int c = 0; c < NCH; c++) begin
            beat_ext[c] = {{(AW+1-IW){in_data[c*IW+IW-1]}}, in_data[c*IW +: IW]};
            sum_wide[c] = {acc[c][AW-1], acc[c]} + beat_ext[c];
            sum_sat[c]  = sum_wide[c][AW-1:0];
            if (sum_wide[c][AW] != sum_wide[c][AW-1]) begin
                sat_now[c] = 1'b1;
                sum_sat[c] = sum_wide[c][AW] ? SAT_MIN : SAT_MAX;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. Ready/valid depend only on the
    // registered state, so in_ready returns one cycle after the output
    // handshake rather than combinationally in the same cycle.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (deliver) begin
                    state_next = ACC;
                end
            end
            default: begin
                state_next = ACC;
            end
        endcase
    end

    // Threshold register file. The compare on a last beat reads the
    // registered value, so a write in the same cycle only affects later vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                thr[c] <= '0;
            end
        end else if (thr_we) begin
            for (int c = 0; c < NCH; c++) begin
                if (thr_ch == CW'(c)) begin
                    thr[c] <= thr_data;
                end
            end
        end
    end

    // Accumulators, sticky saturation flags and the result registers.
    // A last beat folds its own sum and saturation into the result, then
    // clears the running state so the next vector starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                acc[c] <= '0;
            end
            sat      <= '0;
            out_bits <= '0;
            out_sat  <= '0;
        end else if (accept) begin
            if (in_last) begin
                for (int c = 0; c < NCH; c++) begin
                    acc[c]      <= '0;
                    out_bits[c] <= (sum_sat[c] >= thr[c]);
                end
                out_sat <= sat | sat_now;
                sat     <= '0;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    acc[c] <= sum_sat[c];
                end
                sat <= sat | sat_now;
            end
        end
    end

endmodule

// File: tb/tb_bact_accum.sv
// ---------------------------------------------------------------------------
// tb_bact_accum
//   Self-checking bench for bact_accum (NCH=4, IW=4, AW=8). The reference
//   model keeps per-channel integer totals clamped to the accumulator range
//   after every beat, plus an integer threshold table, and predicts the
//   activation and saturation vectors of each completed vector.
// ---------------------------------------------------------------------------
module tb_bact_accum;

    localparam int NCH = 4;
    localparam int IW  = 4;
    localparam int AW  = 8;
    localparam int ACC_MAX = (1 << (AW-1)) - 1;
    localparam int ACC_MIN = -(1 << (AW-1));

    logic              clk;
    logic              rst_n;
    logic              thr_we;
    logic [1:0]        thr_ch;
    logic [AW-1:0]     thr_data;
    logic              in_valid;
    logic              in_ready;
    logic [NCH*IW-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [NCH-1:0]    out_bits;
    logic [NCH-1:0]    out_sat;

    int compare_count;
    int fail_count;

    int       thr_m [NCH];
    int       acc_m [NCH];
    bit       sat_m [NCH];
    logic [NCH-1:0] exp_bits;
    logic [NCH-1:0] exp_sat;

    bact_accum #(.NCH(NCH), .IW(IW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .thr_we    (thr_we),
        .thr_ch    (thr_ch),
        .thr_data  (thr_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            thr_m[c] = 0;
            acc_m[c] = 0;
            sat_m[c] = 1'b0;
        end
    endtask

    // Reference behaviour for one accepted beat.
    task automatic model_beat(input logic [NCH*IW-1:0] data, input logic last);
        logic signed [IW-1:0] nib;
        int raw;
        for (int c = 0; c < NCH; c++) begin
            nib = data[c*IW +: IW];
            raw = acc_m[c] + int'(nib);
            if (raw != clamp(raw)) sat_m[c] = 1'b1;
            acc_m[c] = clamp(raw);
        end
        if (last) begin
            for (int c = 0; c < NCH; c++) begin
                exp_bits[c] = (acc_m[c] >= thr_m[c]);
                exp_sat[c]  = sat_m[c];
                acc_m[c]    = 0;
                sat_m[c]    = 1'b0;
            end
        end
    endtask

    task automatic write_thr(input int ch, input int val);
        thr_we   = 1'b1;
        thr_ch   = 2'(ch);
        thr_data = AW'(val);
        @(posedge clk); #1;
        thr_we = 1'b0;
        thr_m[ch] = val;
    endtask

    // Presents one beat, waits (bounded) for acceptance, updates the model
    // and, on a last beat, checks the result exactly one clock later.
    // Any thr_we set up by the caller is dropped after the same edge.
    task automatic applyStimulus(input logic [NCH*IW-1:0] data, input logic last,
                                 input string tag);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            thr_we   = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        thr_we   = 1'b0;
        model_beat(data, last);
        if (last) begin
            checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_bits"},  32'(out_bits),  32'(exp_bits));
            checkOutput({tag, "_sat"},   32'(out_sat),   32'(exp_sat));
            checkOutput({tag, "_busy"},  32'(in_ready),  32'd0);
        end
    endtask

    // Accepts the pending vector; ready must stay low in the handshake cycle
    // and come back in the next one.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        #1;
        checkOutput({tag, "_hs_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_after_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_after_ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic run_random_vector(input int idx);
        int nb;
        int kind [NCH];
        int nibv;
        int gap;
        logic [NCH*IW-1:0] data;
        string tag;
        tag = $sformatf("rnd%0d", idx);
        nb  = $urandom_range(1, 30);
        for (int c = 0; c < NCH; c++) kind[c] = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < NCH; c++) begin
                case (kind[c])
                    1:       nibv = $urandom_range(4, 7);
                    2:       nibv = $urandom_range(8, 11);
                    default: nibv = $urandom_range(0, 15);
                endcase
                data[c*IW +: IW] = 4'(nibv);
            end
            gap = $urandom_range(0, 1);
            repeat (gap) begin @(posedge clk); #1; end
            applyStimulus(data, (b == nb - 1), tag);
        end
        gap = $urandom_range(0, 3);
        repeat (gap) begin
            @(posedge clk); #1;
            checkOutput({tag, "_wait_bits"}, 32'(out_bits), 32'(exp_bits));
        end
        drain(tag);
    endtask

    initial begin
        compare_count = 0;
        fail_count    = 0;
        rst_n     = 1'b0;
        thr_we    = 1'b0;
        thr_ch    = '0;
        thr_data  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        exp_bits  = '0;
        exp_sat   = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_bits",  32'(out_bits),  32'd0);
        checkOutput("rst_sat",   32'(out_sat),   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);

        // 1: all-zero single beat, thr=0 -> all ones
        applyStimulus(16'h0000, 1'b1, "t1");
        checkOutput("t1_bits_const", 32'(out_bits), 32'hF);
        drain("t1");

        // 2: ch0 totals 7 and 6 against thr 7
        write_thr(0, 7);
        applyStimulus(16'h0003, 1'b0, "t2a");
        applyStimulus(16'h0003, 1'b0, "t2a");
        applyStimulus(16'h0001, 1'b1, "t2a");
        checkOutput("t2a_bit0", 32'(out_bits[0]), 32'd1);
        drain("t2a");
        applyStimulus(16'h0003, 1'b0, "t2b");
        applyStimulus(16'h0003, 1'b0, "t2b");
        applyStimulus(16'h0000, 1'b1, "t2b");
        checkOutput("t2b_bit0", 32'(out_bits[0]), 32'd0);
        drain("t2b");

        // 3: negative threshold on ch2
        write_thr(2, -3);
        applyStimulus(16'h0800, 1'b0, "t3a");
        applyStimulus(16'h0400, 1'b1, "t3a");
        checkOutput("t3a_bit2", 32'(out_bits[2]), 32'd0);
        drain("t3a");
        applyStimulus(16'h0F00, 1'b0, "t3b");
        applyStimulus(16'h0E00, 1'b1, "t3b");
        checkOutput("t3b_bit2", 32'(out_bits[2]), 32'd1);
        drain("t3b");

        // 4: ch1 saturates at +127
        write_thr(1, 127);
        for (int b = 0; b < 20; b++) applyStimulus(16'h0070, (b == 19), "t4a");
        checkOutput("t4a_bit1", 32'(out_bits[1]), 32'd1);
        checkOutput("t4a_satv", 32'(out_sat), 32'h2);
        drain("t4a");
        applyStimulus(16'h0000, 1'b1, "t4b");
        checkOutput("t4b_satv", 32'(out_sat), 32'h0);
        drain("t4b");

        // 5: stall in HOLD with in_valid high and a threshold write
        applyStimulus(16'h1234, 1'b1, "t5");
        in_valid = 1'b1;
        in_data  = 16'h7777;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                thr_we = 1'b1; thr_ch = 2'd3; thr_data = 8'h40;
            end
            @(posedge clk); #1;
            if (i == 2) begin
                thr_we = 1'b0;
                thr_m[3] = 64;
            end
            checkOutput("t5_ready", 32'(in_ready),  32'd0);
            checkOutput("t5_valid", 32'(out_valid), 32'd1);
            checkOutput("t5_bits",  32'(out_bits),  32'(exp_bits));
            checkOutput("t5_sat",   32'(out_sat),   32'(exp_sat));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("t5");
        applyStimulus(16'h2101, 1'b1, "t5n");
        drain("t5n");

        // 6: threshold write in the same cycle as the last beat
        write_thr(0, 0);
        applyStimulus(16'h0001, 1'b0, "t6a");
        thr_we = 1'b1; thr_ch = 2'd0; thr_data = 8'd5;
        applyStimulus(16'h0002, 1'b1, "t6a");
        thr_m[0] = 5;
        checkOutput("t6a_bit0", 32'(out_bits[0]), 32'd1);
        drain("t6a");
        applyStimulus(16'h0001, 1'b0, "t6b");
        applyStimulus(16'h0002, 1'b1, "t6b");
        checkOutput("t6b_bit0", 32'(out_bits[0]), 32'd0);
        drain("t6b");

        // Reset in the middle of a vector
        applyStimulus(16'h7777, 1'b0, "rm");
        applyStimulus(16'h7777, 1'b0, "rm");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("rm_valid", 32'(out_valid), 32'd0);
        checkOutput("rm_bits",  32'(out_bits),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'h0F01, 1'b0, "rm_post");
        applyStimulus(16'hF0F0, 1'b1, "rm_post");
        drain("rm_post");

        // Reset while a result is pending
        write_thr(2, 9);
        applyStimulus(16'h3456, 1'b1, "rh");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("rh_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rh_ready", 32'(in_ready), 32'd1);
        applyStimulus(16'h0000, 1'b1, "rh_post");
        drain("rh_post");

        // Randomized vectors with occasional threshold updates
        for (int v = 0; v < 40; v++) begin
            if ($urandom_range(0, 2) == 0) begin
                write_thr($urandom_range(0, NCH-1), int'($urandom_range(0, 100)) - 50);
            end
            run_random_vector(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
